wb_approx_mul_v2: RTL
=====================

WB_APPROX_MUL_V2 -- requirements
Module: wb_approx_mul_v2

Interface
REQ-001 Parameter WIDTH, default 16, meaning operand width in bits (legal 4..16).
REQ-002 Parameter STAGES, default 2, meaning multiplier pipeline depth in cycles (legal 1..4).
REQ-003 Parameter BASE_ADDR, default 32'h3000_0000, meaning Wishbone base address; decode on wbs_adr_i[31:8].
REQ-004 wb_clk_i  input  1  sole clock; all state on its rising edge.
REQ-005 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-006 wbs_cyc_i / wbs_stb_i / wbs_we_i  input  1 each  Wishbone classic cycle, strobe, write-enable.
REQ-007 wbs_sel_i  input  4  byte enables for writes.
REQ-008 wbs_adr_i / wbs_dat_i  input  32 each  address, write data.
REQ-009 wbs_ack_o  output  1  transfer acknowledge.
REQ-010 wbs_dat_o  output  32  read data.
REQ-011 irq  output  1  completion interrupt, level.

Function
REQ-012 Register map (offset = wbs_adr_i[7:0]): 0x00 OPA, 0x04 OPB (WIDTH bits, RW); 0x08 CTRL (RW); 0x0C STATUS; 0x10 RESULT_LO; 0x14 RESULT_HI (RO).
REQ-013 CTRL: bit0 START (write-1 pulse, reads 0); bit1 MODE (0 exact, 1 truncated); bit3 SIGNED (two's complement); bits[7:4] K; bit8 IRQ_EN.
REQ-014 STATUS: bit0 BUSY; bit1 DONE (sticky); bit2 ERR (sticky, write-1-to-clear); other bits read 0.
REQ-015 Ack: when cyc&stb&address-match and ack low, ack high exactly one cycle next edge; never on consecutive cycles; no ack for non-matching addresses.
REQ-016 Writes take effect at ack edge, per-byte per wbs_sel_i; bits above WIDTH ignored, read 0.
REQ-017 Unmapped offsets in range: reads return 0 with ack, writes ignored with ack.
REQ-018 Reads return register value sampled at ack edge; wbs_dat_o is 0 when ack low.
REQ-019 Start accepted when START written 1 and BUSY=0: OPA, OPB, MODE, SIGNED, K latched at that edge; later operand writes affect only the next operation.
REQ-020 BUSY=1 the cycle after acceptance, for exactly STAGES cycles; on its falling edge RESULT and DONE=1 update in the same cycle.
REQ-021 MODE=1: low min(K,WIDTH-1) bits of each latched operand forced 0 before multiply; MODE=0 ignores K.
REQ-022 Product is full 2*WIDTH bits; SIGNED=1 sign-extends to 64 bits across RESULT_HI:RESULT_LO, SIGNED=0 zero-extends.
REQ-023 START while BUSY=1: ignored, ERR set, in-flight operation unaffected.
REQ-024 DONE cleared by accepted start or by a read of RESULT_LO; set has priority if both in the same cycle.
REQ-025 irq = DONE & IRQ_EN.

Reset
REQ-026 On wb_rst_i high at an edge: all registers, pipeline, BUSY, DONE, ERR, wbs_ack_o, wbs_dat_o, irq = 0.
REQ-027 Reset mid-operation aborts it; no DONE, irq or RESULT update afterwards.
REQ-028 Wishbone cycle open during reset receives no ack; responses resume the cycle after reset deasserts.

Verification (WIDTH=16, STAGES=2)
REQ-029 OPA=0x00FF, OPB=0x0101, CTRL=0x001 -> BUSY 2 cycles, RESULT_LO=0x0000FFFF, RESULT_HI=0, DONE=1.
REQ-030 OPA=0xFFFE, OPB=0x0003, CTRL=0x009 -> RESULT_LO=0xFFFFFFFA, RESULT_HI=0xFFFFFFFF.
REQ-031 OPA=0x00FF, OPB=0x0011, CTRL=0x143 (K=4, MODE=1, IRQ_EN) -> RESULT_LO=0x00000F00, irq=1 until RESULT_LO read.
REQ-032 START written again while BUSY -> ERR=1, single DONE, first result intact; write STATUS=0x4 -> ERR=0.
REQ-033 wb_rst_i pulsed while BUSY -> all outputs 0, no DONE/irq over the following 10 cycles.
REQ-034 OPA=0xFFFF then write 0x1234 with sel=0001 -> OPA=0xFF34; read offset 0x20 -> ack, data 0; address 0x3100_0000 -> no ack.

Source files
------------

// File: rtl/wb_approx_mul_v2.sv
// Wishbone-attached approximate multiplier: operand/control registers, a STAGES-deep
// multiply pipeline with optional low-bit truncation, sticky status and a level interrupt.
module wb_approx_mul_v2 #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned STAGES    = 2,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned KW     = 4;
  localparam int unsigned PIPE_N = (STAGES > 1) ? STAGES - 1 : 1;
  localparam logic [KW-1:0] K_MAX = KW'(WIDTH - 1);

  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RES_LO = 8'h10;
  localparam logic [7:0] OFF_RES_HI = 8'h14;

  // Architectural registers
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             mode_q, sgn_q, irq_en_q;
  logic [KW-1:0]    k_q;
  logic             err_q, done_q;
  logic [63:0]      result_q;

  // Operation in flight
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  op_a_q, op_b_q;
  logic              op_sgn_q;
  logic [PW-1:0]     pipe_q [PIPE_N];

  // Next-state values
  logic [WIDTH-1:0]  opa_d, opb_d, op_a_d, op_b_d;
  logic              mode_d, sgn_d, irq_en_d, err_d, done_d, op_sgn_d;
  logic [KW-1:0]     k_d;
  logic [63:0]       result_d;
  logic [STAGES-1:0] v_d;
  logic              ack_d, irq_d;
  logic [31:0]       dat_d;

  // Bus decode
  logic             req_c, wr_c, rd_c, busy_c, start_c, accept_c;
  logic [7:0]       off_c;
  logic [31:0]      lane32_c;
  logic [WIDTH-1:0] lane_c, opa_w_c, opb_w_c, tmask_c;
  logic             mode_w_c, sgn_w_c, irq_en_w_c;
  logic [KW-1:0]    k_w_c, kk_c;
  logic [PW-1:0]    ext_a_c, ext_b_c, prod_c, tail_c;
  logic [63:0]      res_ext_c;
  logic [31:0]      status_c, ctrl_c, rdata_c;
  logic             unused_c;

  assign req_c    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
  assign wr_c     = req_c & wbs_we_i;
  assign rd_c     = req_c & ~wbs_we_i;
  assign off_c    = wbs_adr_i[7:0];
  assign busy_c   = |v_q;
  assign start_c  = wr_c & (off_c == OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[0];
  assign accept_c = start_c & ~busy_c;

  assign lane32_c = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign lane_c   = lane32_c[WIDTH-1:0];
  assign opa_w_c  = (opa_q & ~lane_c) | (wbs_dat_i[WIDTH-1:0] & lane_c);
  assign opb_w_c  = (opb_q & ~lane_c) | (wbs_dat_i[WIDTH-1:0] & lane_c);

  // Control fields as they stand after this write (start uses the freshly written ones)
  assign mode_w_c   = wbs_sel_i[0] ? wbs_dat_i[1]   : mode_q;
  assign sgn_w_c    = wbs_sel_i[0] ? wbs_dat_i[3]   : sgn_q;
  assign k_w_c      = wbs_sel_i[0] ? wbs_dat_i[7:4] : k_q;
  assign irq_en_w_c = wbs_sel_i[1] ? wbs_dat_i[8]   : irq_en_q;

  assign kk_c    = (k_w_c > K_MAX) ? K_MAX : k_w_c;
  assign tmask_c = {WIDTH{1'b1}} << kk_c;

  assign unused_c = ^{wbs_dat_i, wbs_sel_i, lane32_c};

  // Multiply: sign/zero extension to 2*WIDTH makes the truncated product correct for both modes
  assign ext_a_c = {{WIDTH{op_sgn_q & op_a_q[WIDTH-1]}}, op_a_q};
  assign ext_b_c = {{WIDTH{op_sgn_q & op_b_q[WIDTH-1]}}, op_b_q};
  assign prod_c  = ext_a_c * ext_b_c;

  generate
    if (STAGES == 1) begin : g_tail_direct
      assign tail_c = prod_c;
    end else begin : g_tail_pipe
      assign tail_c = pipe_q[STAGES-2];
    end
  endgenerate

  assign res_ext_c = {{(64-PW){op_sgn_q & tail_c[PW-1]}}, tail_c};

  assign status_c = {29'b0, err_q, done_q, busy_c};
  assign ctrl_c   = {23'b0, irq_en_q, k_q, sgn_q, 1'b0, mode_q, 1'b0};

  // Read mux
  always_comb begin
    rdata_c = '0;
    case (off_c)
      OFF_OPA:    rdata_c = 32'(opa_q);
      OFF_OPB:    rdata_c = 32'(opb_q);
      OFF_CTRL:   rdata_c = ctrl_c;
      OFF_STATUS: rdata_c = status_c;
      OFF_RES_LO: rdata_c = result_q[31:0];
      OFF_RES_HI: rdata_c = result_q[63:32];
      default:    rdata_c = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    mode_d   = mode_q;
    sgn_d    = sgn_q;
    k_d      = k_q;
    irq_en_d = irq_en_q;
    err_d    = err_q;
    done_d   = done_q;
    result_d = result_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_sgn_d = op_sgn_q;
    v_d      = v_q << 1;
    v_d[0]   = accept_c;
    ack_d    = req_c;
    dat_d    = rd_c ? rdata_c : '0;

    if (wr_c) begin
      case (off_c)
        OFF_OPA: opa_d = opa_w_c;
        OFF_OPB: opb_d = opb_w_c;
        OFF_CTRL: begin
          mode_d   = mode_w_c;
          sgn_d    = sgn_w_c;
          k_d      = k_w_c;
          irq_en_d = irq_en_w_c;
        end
        OFF_STATUS: if (wbs_sel_i[0] && wbs_dat_i[2]) err_d = 1'b0;
        default: ;
      endcase
    end

    if (start_c && busy_c) err_d = 1'b1;

    if (accept_c) begin
      op_a_d   = mode_w_c ? (opa_q & tmask_c) : opa_q;
      op_b_d   = mode_w_c ? (opb_q & tmask_c) : opb_q;
      op_sgn_d = sgn_w_c;
    end

    // Completion wins over a same-cycle clear
    if (accept_c || (rd_c && (off_c == OFF_RES_LO))) done_d = 1'b0;
    if (v_q[STAGES-1]) begin
      done_d   = 1'b1;
      result_d = res_ext_c;
    end

    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      opa_q     <= '0;
      opb_q     <= '0;
      mode_q    <= 1'b0;
      sgn_q     <= 1'b0;
      k_q       <= '0;
      irq_en_q  <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_sgn_q  <= 1'b0;
      v_q       <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq       <= 1'b0;
      for (int i = 0; i < int'(PIPE_N); i++) pipe_q[i] <= '0;
    end else begin
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      mode_q    <= mode_d;
      sgn_q     <= sgn_d;
      k_q       <= k_d;
      irq_en_q  <= irq_en_d;
      err_q     <= err_d;
      done_q    <= done_d;
      result_q  <= result_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_sgn_q  <= op_sgn_d;
      v_q       <= v_d;
      wbs_ack_o <= ack_d;
      wbs_dat_o <= dat_d;
      irq       <= irq_d;
      pipe_q[0] <= prod_c;
      for (int i = 1; i < int'(PIPE_N); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

endmodule
